// File: rtl/bk_pkg.sv
// Shared Brent-Kung arithmetic package: nibble width, subtractor FSM states
// and the bitwise propagate/generate helpers used by both adder and subtractor.
package bk_pkg;

  localparam int BK_NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bk_sub_state_t;

  // Bitwise generate: a carry is created at this position regardless of carry-in.
  function automatic logic [BK_NIB_W-1:0] bk_gen(input logic [BK_NIB_W-1:0] x,
                                                 input logic [BK_NIB_W-1:0] y);
    return x & y;
  endfunction

  // Bitwise propagate: an incoming carry passes through this position.
  function automatic logic [BK_NIB_W-1:0] bk_prop(input logic [BK_NIB_W-1:0] x,
                                                  input logic [BK_NIB_W-1:0] y);
    return x ^ y;
  endfunction

endpackage

// File: rtl/bk_sub_nibble.sv
// 4-bit Brent-Kung prefix cell. Purely combinational; the caller supplies the
// already-inverted subtrahend nibble in y and the running carry in cin.
module bk_sub_nibble
  import bk_pkg::*;
(
  input  logic [BK_NIB_W-1:0] x,
  input  logic [BK_NIB_W-1:0] y,
  input  logic                cin,
  output logic [BK_NIB_W-1:0] s,
  output logic                cout
);

  logic [BK_NIB_W-1:0] g;
  logic [BK_NIB_W-1:0] p;
  logic                g10, p10, g32, p32;
  logic                g20, p20, g30, p30;
  logic [BK_NIB_W-1:0] c;

  // Prefix tree: pairwise up-sweep, then the root and the single down-sweep
  // node for bit 2, then carries formed against cin and the final sum.
  always_comb begin
    g   = bk_gen(x, y);
    p   = bk_prop(x, y);
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g30 = g32 | (p32 & g10);
    p30 = p32 & p10;
    g20 = g[2] | (p[2] & g10);
    p20 = p[2] & p10;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g10  | (p10  & cin);
    c[3] = g20  | (p20  & cin);
    cout = g30  | (p30  & cin);
    s    = p ^ c;
  end

endmodule

// File: rtl/bk_serial_sub.sv
// Nibble-serial subtractor diff = a - b built around one Brent-Kung nibble cell,
// with valid/ready handshakes on both sides. Optional signed-overflow output
// is enabled by defining BK_SUB_OVF_EN.
module bk_serial_sub
  import bk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
`ifdef BK_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / BK_NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  bk_sub_state_t        state;
  bk_sub_state_t        next_state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_inv;
  logic                 carry;
  logic [IDX_W-1:0]     idx;
  logic                 accept;
  logic                 last_nib;
  logic [BK_NIB_W-1:0]  nib_x;
  logic [BK_NIB_W-1:0]  nib_y;
  logic [BK_NIB_W-1:0]  nib_s;
  logic                 nib_cout;
  logic [WIDTH-1:0]     diff_next;

  // Select the current nibble of each operand and merge the new sum into diff.
  always_comb begin
    nib_x     = a_reg[idx*BK_NIB_W +: BK_NIB_W];
    nib_y     = b_inv[idx*BK_NIB_W +: BK_NIB_W];
    last_nib  = (idx == IDX_W'(NIB - 1));
    diff_next = diff;
    diff_next[idx*BK_NIB_W +: BK_NIB_W] = nib_s;
  end

  bk_sub_nibble u_nibble (
    .x    (nib_x),
    .y    (nib_y),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // Next-state and handshake outputs; operands are only accepted in IDLE.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_nib) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and datapath: capture on accept, one nibble per RUN cycle,
  // flags latched when the top nibble completes and held until the next result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_inv  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        a_reg <= a;
        b_inv <= ~b;
        carry <= 1'b1;
        idx   <= '0;
      end else if (state == RUN) begin
        diff  <= diff_next;
        carry <= nib_cout;
        idx   <= idx + IDX_W'(1);
        if (last_nib) begin
          borrow <= ~nib_cout;
          zero   <= (diff_next == '0);
        end
      end
    end
  end

`ifdef BK_SUB_OVF_EN
  // Signed overflow: operand signs differ and the result sign differs from a.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == RUN && last_nib) begin
      ovf <= (a_reg[WIDTH-1] != ~b_inv[WIDTH-1]) &&
             (nib_s[BK_NIB_W-1] != a_reg[WIDTH-1]);
    end
  end
`endif

endmodule

// File: doc/bk_serial_sub.md
# bk_serial_sub

Multi-cycle unsigned/two's-complement subtractor computing `diff = a - b` one nibble per clock through a single 4-bit Brent-Kung prefix cell. It is the inverse-direction companion of the team's 4-bit Brent-Kung adder: same P/G prefix network, with `b` inverted, carry-in forced to 1 and a registered carry/borrow chain. It sits behind a valid/ready handshake so it can be chained with other arithmetic blocks in the tile.

## Interface
Parameters:
- `WIDTH`, default 16: operand width. Must be a multiple of 4 and ≥ 4. `NIB = WIDTH/4` nibble steps.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands `a`/`b` valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `diff`  out  WIDTH  `a - b` modulo 2^WIDTH.
- `borrow`  out  1  1 when `a < b` unsigned, i.e. the inverse of the final carry.
- `zero`  out  1  1 when `diff == 0`.
- `ovf`  out  1  signed overflow; present only with `BK_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: `in_ready=1`. On `in_valid && in_ready`, capture `a`, `b` and `~b`. Set carry=1 and nibble index=0, then go to RUN.
- RUN: each cycle the nibble cell computes `a[4i+3:4i] + ~b[4i+3:4i] + carry`.
  - Its 4-bit sum is written to `diff[4i+3:4i]`, its carry-out is registered, and i increments.
  - When i==NIB-1 completes: `borrow = ~carry_out` and `zero = (full diff == 0)`. Go to DONE.
- DONE: `out_valid=1`. On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. `in_valid` in RUN/DONE is ignored; operands are not queued.
- `diff`, `borrow`, `zero` (and `ovf`) are registered.
  - They are stable for the whole DONE state.
  - After the handshake they retain the last result until the next result overwrites them.
  - Intermediate nibble writes during RUN are not qualified by `out_valid`.
- Arithmetic is modulo 2^WIDTH. Carry-out of the top nibble is never folded into `diff`.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `diff=0`, `borrow=0`, `zero=0`, `ovf=0`. State=IDLE, index=0, carry=0.
- `rst` has priority over every handshake. Asserting it in RUN or DONE aborts the operation and returns to IDLE the next cycle; no result is emitted.
- Latency: accept edge E0. RUN covers edges E0+1..E0+NIB. `out_valid` is high from the cycle after edge E0+NIB (4 cycles for WIDTH=16).
- Result handshake at edge Ek (`out_valid && out_ready`) gives `in_ready=1` in the next cycle. Throughput is one op per NIB+2 cycles.
- `out_ready` may be high before `out_valid`. The transfer occurs on the first edge where both are high.
- `out_valid` never drops without a handshake or `rst`.

## Configuration
- `BK_SUB_OVF_EN` defined:
  - The `ovf` port exists.
  - `ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])`, registered at the same edge as `borrow`.
- Not defined: no `ovf` port and no sign-bit capture logic. All other behaviour is identical.

## Structure
- Shared package `bk_pkg`:
  - nibble width constant `BK_NIB_W = 4`;
  - FSM state enum `bk_sub_state_t` {IDLE, RUN, DONE};
  - the P/G function helpers also used by the adder.
- One sub-module `bk_sub_nibble`: 4-bit Brent-Kung prefix cell with inputs `x[3:0]`, `y[3:0]` (already inverted) and `cin`, outputs `s[3:0]` and `cout`. It is purely combinational and instantiated once.

## Test plan
- `a=0x1234`, `b=0x0234` → `diff=0x1000`, `borrow=0`, `zero=0`. `out_valid` high exactly 4 cycles after accept.
- `a=0x0000`, `b=0x0001` → `diff=0xFFFF`, `borrow=1`, `zero=0` (full borrow ripple through all nibbles).
- `a=0x5A5A`, `b=0x5A5A` → `diff=0x0000`, `zero=1`, `borrow=0`.
- Hold `out_ready=0` for 3 cycles after `out_valid` → outputs stable and `in_ready=0`. A new `in_valid` with `a=0xFFFF` during that window is ignored, and the result is unchanged.
- `rst=1` for one cycle during the second RUN cycle → next cycle `in_ready=1` and `out_valid=0`. A fresh op `0x0010-0x0001` then gives `0x000F`.
- With `BK_SUB_OVF_EN`: `0x8000-0x0001` → `diff=0x7FFF`, `ovf=1`, `borrow=0`. `0x7FFF-0x0001` → `ovf=0`.
